// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine coin path: FSM states,
// default credit width, ceiling and coin denominations.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_REFUND  = 2'd3
  } state_t;

  localparam int unsigned CREDIT_W   = 8;
  localparam int unsigned MAX_CREDIT = 7;
  localparam int unsigned VAL1       = 1;
  localparam int unsigned VAL2       = 2;
  localparam int unsigned VAL5       = 5;

endpackage

// File: rtl/coin_acceptor_input_debouncer.sv
// Conditions one raw asynchronous input: 2-FF synchroniser, stability
// counter, and a one-cycle pulse on the rising edge of the debounced level.
module input_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_event
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_level_d;
  logic             r_event;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_event   <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      // The edge that would make the count reach DEBOUNCE_CYCLES flips the level.
      if (r_sync2 != r_level) begin
        if (r_cnt == CNT_LAST) begin
          r_level <= r_sync2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
      r_level_d <= r_level;
      r_event   <= r_level & ~r_level_d;
    end
  end

  assign o_event = r_event;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounces coin/cancel inputs, accumulates credit up to a
// ceiling, freezes it while the controller vends, and refunds on cancel.
module coin_acceptor #(
  parameter int unsigned CREDIT_W        = vm_pkg::CREDIT_W,
  parameter int unsigned MAX_CREDIT      = vm_pkg::MAX_CREDIT,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned VAL1            = vm_pkg::VAL1,
  parameter int unsigned VAL2            = vm_pkg::VAL2,
  parameter int unsigned VAL5            = vm_pkg::VAL5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin1_in,
  input  logic                coin2_in,
  input  logic                coin5_in,
  input  logic                cancel_in,
  input  logic                lock,
  input  logic                take,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_accepted,
  output logic                coin_reject,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount
);

  import vm_pkg::*;

  localparam int unsigned SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    L_MAX  = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0]    L_V1   = SUM_W'(VAL1);
  localparam logic [SUM_W-1:0]    L_V2   = SUM_W'(VAL2);
  localparam logic [SUM_W-1:0]    L_V5   = SUM_W'(VAL5);
  localparam logic [CREDIT_W-1:0] C_V1   = CREDIT_W'(VAL1);
  localparam logic [CREDIT_W-1:0] C_V2   = CREDIT_W'(VAL2);
  localparam logic [CREDIT_W-1:0] C_V5   = CREDIT_W'(VAL5);

  logic w_ev1, w_ev2, w_ev5, w_cancel;

  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin1 (
    .i_clk(clk), .i_rst_n(reset), .i_raw(coin1_in), .o_event(w_ev1)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin2 (
    .i_clk(clk), .i_rst_n(reset), .i_raw(coin2_in), .o_event(w_ev2)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_coin5 (
    .i_clk(clk), .i_rst_n(reset), .i_raw(coin5_in), .o_event(w_ev5)
  );
  input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .i_clk(clk), .i_rst_n(reset), .i_raw(cancel_in), .o_event(w_cancel)
  );

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_coin_accepted;
  logic                r_coin_reject;
  logic                r_refund_valid;
  logic [CREDIT_W-1:0] r_refund_amount;
  logic [1:0]          r_rej_pend;

  logic [SUM_W-1:0]    w_base;
  logic [CREDIT_W-1:0] w_add;
  logic                w_fit1, w_fit2, w_fit5;
  logic                w_open;
  logic                w_pick1, w_pick2, w_pick5, w_acc;
  logic [1:0]          w_n_coin, w_n_rej;
  logic [2:0]          w_rej_total;

  always_comb begin
    w_base  = {1'b0, r_credit};
    w_fit1  = (w_base + L_V1) <= L_MAX;
    w_fit2  = (w_base + L_V2) <= L_MAX;
    w_fit5  = (w_base + L_V5) <= L_MAX;
    // Coins are only taken when unlocked and no cancel arrives in the same cycle.
    w_open  = ((r_state == ST_IDLE) || (r_state == ST_COLLECT)) && !lock && !w_cancel;
    w_pick5 = w_open && w_ev5 && w_fit5;
    w_pick2 = w_open && w_ev2 && w_fit2 && !w_pick5;
    w_pick1 = w_open && w_ev1 && w_fit1 && !w_pick5 && !w_pick2;
    w_acc   = w_pick1 | w_pick2 | w_pick5;
    w_add   = w_pick5 ? C_V5 : (w_pick2 ? C_V2 : (w_pick1 ? C_V1 : '0));
    w_n_coin    = 2'(w_ev1) + 2'(w_ev2) + 2'(w_ev5);
    w_n_rej     = w_n_coin - 2'(w_acc);
    w_rej_total = 3'(r_rej_pend) + 3'(w_n_rej);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_credit        <= '0;
      r_coin_accepted <= 1'b0;
      r_coin_reject   <= 1'b0;
      r_refund_valid  <= 1'b0;
      r_refund_amount <= '0;
      r_rej_pend      <= '0;
    end else begin
      r_coin_accepted <= w_acc;
      r_refund_valid  <= 1'b0;
      r_refund_amount <= '0;

      // Rejects drain one per cycle; surplus beyond two waiting is capped.
      if (w_rej_total == '0) begin
        r_coin_reject <= 1'b0;
        r_rej_pend    <= '0;
      end else begin
        r_coin_reject <= 1'b1;
        r_rej_pend    <= (w_rej_total > 3'd2) ? 2'd2 : 2'(w_rej_total - 3'd1);
      end

      unique case (r_state)
        ST_IDLE, ST_COLLECT: begin
          if (lock) begin
            r_state <= ST_LOCKED;
          end else if (w_cancel) begin
            if (r_state == ST_COLLECT) begin
              r_refund_valid  <= 1'b1;
              r_refund_amount <= r_credit;
              r_credit        <= '0;
              r_state         <= ST_REFUND;
            end
          end else if (w_acc) begin
            r_credit <= r_credit + w_add;
            r_state  <= ST_COLLECT;
          end
        end
        ST_LOCKED: begin
          if (take) begin
            r_credit <= '0;
            r_state  <= ST_IDLE;
          end else if (!lock) begin
            r_state <= (r_credit != '0) ? ST_COLLECT : ST_IDLE;
          end
        end
        ST_REFUND: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign credit        = r_credit;
  assign coin_accepted = r_coin_accepted;
  assign coin_reject   = r_coin_reject;
  assign refund_valid  = r_refund_valid;
  assign refund_amount = r_refund_amount;

endmodule
